// File: rtl/vthernet_pkg.sv
// Shared constants for the vthernet receive path.
//   OCT          : byte width
//   DEF_*        : default buffer geometry (2 banks x 1024 bytes)
//   rx_state_e   : receive-buffer FSM states
package vthernet_pkg;
  localparam int OCT         = 8;
  localparam int DEF_ADDR_W  = 11;
  localparam int DEF_MAX_LEN = 1024;
  localparam int DEF_LEN_W   = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } rx_state_e;
endpackage

// File: rtl/rx_bank_ctrl.sv
// Two-entry ping-pong bank bookkeeping for the UDP receive buffer.
// Holds per-bank valid/len/ovf, the write-bank and read-bank pointers, and
// resolves commit (from the fill side) against rel (from the host).
// Ports:
//   RX_CLK, rst_n          clock, synchronous active-low reset
//   commit/commit_len/ovf  latch the current write bank as a finished datagram
//   rel                    host frees the head bank (ignored if none pending)
//   wr_bank, wr_free       bank the next frame goes to, and whether it is empty
//   rx_irq                 any bank pending
//   rd_bank/rd_len/rd_ovf  head datagram view (len/ovf zero when idle)
import vthernet_pkg::*;

module rx_bank_ctrl #(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             RX_CLK,
  input  logic             rst_n,
  input  logic             commit,
  input  logic [LEN_W-1:0] commit_len,
  input  logic             commit_ovf,
  input  logic             rel,
  output logic             wr_bank,
  output logic             wr_free,
  output logic             rx_irq,
  output logic             rd_bank,
  output logic [LEN_W-1:0] rd_len,
  output logic             rd_ovf
);
  logic [1:0]            vld_q;
  logic [1:0][LEN_W-1:0] len_q;
  logic [1:0]            ovf_q;
  logic                  wr_q, rd_q;
  logic                  rel_ok;

  assign rel_ok = rel & vld_q[rd_q];

  // A commit always targets wr_q, which is empty whenever a commit can occur;
  // a release targets the occupied rd_q. When both fire they touch different
  // banks, so they can be applied independently.
  always_ff @(posedge RX_CLK) begin
    if (!rst_n) begin
      vld_q <= '0;
      len_q <= '0;
      ovf_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      if (commit) begin
        vld_q[wr_q] <= 1'b1;
        len_q[wr_q] <= commit_len;
        ovf_q[wr_q] <= commit_ovf;
        wr_q        <= ~wr_q;
      end
      if (rel_ok) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= ~rd_q;
      end
    end
  end

  assign wr_bank = wr_q;
  assign wr_free = ~vld_q[wr_q];
  assign rx_irq  = |vld_q;
  assign rd_bank = rd_q;
  assign rd_len  = vld_q[rd_q] ? len_q[rd_q] : '0;
  assign rd_ovf  = vld_q[rd_q] & ovf_q[rd_q];
endmodule

// File: rtl/rx_udp_buffer.sv
// UDP payload receive buffer: writes each datagram from the per-byte payload
// stream into one of two ping-pong banks of an external byte RAM, records its
// length/overflow, and raises rx_irq while a committed bank awaits the host.
// Optional feature macro: RX_BUF_DROP_CNT_EN adds drop_cnt[15:0], a saturating
// count of frames discarded because both banks were full.
// Ports:
//   RX_CLK, rst_n                 clock, synchronous active-low reset
//   rx_udp_data_v, rx_udp_data    payload stream, one high run per datagram
//   mem_we, mem_addr, mem_wdata   RAM write port, one cycle after byte accept
//   rel                           host frees the head bank
//   rx_irq, rd_bank, rd_len, rd_ovf  head datagram status
//   drop_cnt                      (RX_BUF_DROP_CNT_EN only) dropped frame count
import vthernet_pkg::*;

module rx_udp_buffer #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic              RX_CLK,
  input  logic              rst_n,
  input  logic              rx_udp_data_v,
  input  logic [OCT-1:0]    rx_udp_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OCT-1:0]    mem_wdata,
  input  logic              rel,
  output logic              rx_irq,
  output logic              rd_bank,
  output logic [LEN_W-1:0]  rd_len,
`ifdef RX_BUF_DROP_CNT_EN
  output logic              rd_ovf,
  output logic [15:0]       drop_cnt
`else
  output logic              rd_ovf
`endif
);
  localparam int               OFF_W = ADDR_W - 1;
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  rx_state_e         state_q, state_d;
  logic [LEN_W-1:0]  off_q;
  logic              ovf_q;
  logic              acc, start_fill, start_drop, commit;
  logic [LEN_W-1:0]  wr_off;
  logic              wr_bank, wr_free;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [OCT-1:0]    mem_wdata_q;

  always_ff @(posedge RX_CLK) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    acc        = 1'b0;
    start_fill = 1'b0;
    start_drop = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: if (rx_udp_data_v) begin
        if (wr_free) begin
          state_d    = FILL;
          acc        = 1'b1;
          start_fill = 1'b1;
        end else begin
          state_d    = DROP;
          start_drop = 1'b1;
        end
      end
      FILL: begin
        if (rx_udp_data_v) acc = (off_q < MAX_L);
        else begin
          state_d = IDLE;
          commit  = 1'b1;
        end
      end
      DROP: if (!rx_udp_data_v) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first byte of a frame is written at offset 0 while off_q is still
  // left over from the previous frame.
  assign wr_off = start_fill ? '0 : off_q;

  // off_q counts stored bytes and stops at MAX_LEN, so it doubles as the
  // committed length and can never carry into the bank bit.
  always_ff @(posedge RX_CLK) begin
    if (!rst_n) begin
      off_q <= '0;
      ovf_q <= 1'b0;
    end else if (start_fill) begin
      off_q <= LEN_W'(1);
      ovf_q <= 1'b0;
    end else if (state_q == FILL && rx_udp_data_v) begin
      if (acc) off_q <= off_q + 1'b1;
      else     ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge RX_CLK) begin
    if (!rst_n) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= acc;
      if (acc) begin
        mem_addr_q  <= {wr_bank, wr_off[OFF_W-1:0]};
        mem_wdata_q <= rx_udp_data;
      end
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  rx_bank_ctrl #(.LEN_W(LEN_W)) u_bank (
    .RX_CLK     (RX_CLK),
    .rst_n      (rst_n),
    .commit     (commit),
    .commit_len (off_q),
    .commit_ovf (ovf_q),
    .rel        (rel),
    .wr_bank    (wr_bank),
    .wr_free    (wr_free),
    .rx_irq     (rx_irq),
    .rd_bank    (rd_bank),
    .rd_len     (rd_len),
    .rd_ovf     (rd_ovf)
  );

`ifdef RX_BUF_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Entering DROP implies both banks are pending, so an increment and a
  // clear (rel with nothing pending) can never coincide.
  always_ff @(posedge RX_CLK) begin
    if (!rst_n)                              drop_cnt_q <= '0;
    else if (start_drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
    else if (rel && !rx_irq)                 drop_cnt_q <= '0;
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_rx_udp_buffer.sv
module tb_rx_udp_buffer;
  import vthernet_pkg::*;

  localparam int ADDR_W  = 11;
  localparam int MAX_LEN = 1024;
  localparam int LEN_W   = 11;

  logic              RX_CLK = 1'b0;
  logic              rst_n  = 1'b0;
  logic              dv     = 1'b0;
  logic [7:0]        din    = 8'h00;
  logic              rel    = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              rx_irq, rd_bank, rd_ovf;
  logic [LEN_W-1:0]  rd_len;
`ifdef RX_BUF_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  rx_udp_buffer #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .RX_CLK        (RX_CLK),
    .rst_n         (rst_n),
    .rx_udp_data_v (dv),
    .rx_udp_data   (din),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .rel           (rel),
    .rx_irq        (rx_irq),
    .rd_bank       (rd_bank),
    .rd_len        (rd_len),
`ifdef RX_BUF_DROP_CNT_EN
    .rd_ovf        (rd_ovf),
    .drop_cnt      (drop_cnt)
`else
    .rd_ovf        (rd_ovf)
`endif
  );

  always #5 RX_CLK = ~RX_CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: list of pending datagrams in arrival order, the bank the
  // next accepted frame will use, and the dropped-frame counter.
  typedef struct {
    int len;
    bit ovf;
    bit bank;
  } ent_t;
  ent_t        pend[$];
  bit          m_wr;
  int          m_drop;
  logic [18:0] expq[$];   // expected writes {addr, data} in order

  // Write scoreboard: every observed write must be the next expected one.
  always @(negedge RX_CLK) begin
    if (mem_we) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%h data=%h required none", mem_addr, mem_wdata);
      end else begin
        logic [18:0] e;
        e = expq.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          bad++;
          $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                   mem_addr, mem_wdata, e[18:8], e[7:0]);
        end
      end
    end
  end

  function automatic logic [13:0] exp_state();
    if (pend.size() == 0) return {1'b0, m_wr, 11'd0, 1'b0};
    return {1'b1, pend[0].bank, 11'(pend[0].len), pend[0].ovf};
  endfunction

  task automatic do_reset();
    @(negedge RX_CLK);
    rst_n = 1'b0; dv = 1'b0; rel = 1'b0;
    @(negedge RX_CLK);
    rst_n = 1'b1;
    pend.delete(); expq.delete();
    m_wr = 1'b0; m_drop = 0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge RX_CLK);
      dv = 1'b0; rel = 1'b0;
    end
  endtask

  task automatic pulse_rel();
    @(negedge RX_CLK);
    dv = 1'b0; rel = 1'b1;
    if (pend.size() > 0) void'(pend.pop_front());
    else m_drop = 0;
    @(negedge RX_CLK);
    rel = 1'b0;
  endtask

  // Drives one frame; leaves data_v low (and rel=rel_end) for the cycle after it.
  task automatic send_frame(input int n, input bit rnd, input bit rel_end);
    bit   take;
    bit   b;
    ent_t e;
    take = (pend.size() < 2);
    b    = m_wr;
    for (int i = 0; i < n; i++) begin
      @(negedge RX_CLK);
      dv = 1'b1; rel = 1'b0;
      din = rnd ? 8'($urandom) : 8'(i);
      if (take && i < MAX_LEN) expq.push_back({b, 10'(i), din});
    end
    @(negedge RX_CLK);
    dv = 1'b0; rel = rel_end;
    if (!take && m_drop < 65535) m_drop++;
    if (rel_end) begin
      if (pend.size() > 0) void'(pend.pop_front());
      else m_drop = 0;
    end
    if (take) begin
      e.len  = (n > MAX_LEN) ? MAX_LEN : n;
      e.ovf  = (n > MAX_LEN);
      e.bank = b;
      pend.push_back(e);
      m_wr = ~m_wr;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_we, mem_addr, mem_wdata} !== 20'd0) begin
      bad++;
      $display("FAIL reset_wr got we=%b addr=%h data=%h required 0", mem_we, mem_addr, mem_wdata);
    end
    total++;
    if ({rx_irq, rd_bank, rd_len, rd_ovf} !== 14'd0) begin
      bad++;
      $display("FAIL reset_rd got irq=%b bank=%b len=%0d ovf=%b required 0", rx_irq, rd_bank, rd_len, rd_ovf);
    end
`ifdef RX_BUF_DROP_CNT_EN
    total++;
    if (drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_drop got %0d required 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_single_frame();
    do_reset();
    send_frame(64, 1'b0, 1'b0);
    idle(1);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL single_writes got %0d missing required 0", expq.size());
    end
    total++;
    if ({rx_irq, rd_bank, rd_len, rd_ovf} !== {1'b1, 1'b0, 11'd64, 1'b0}) begin
      bad++;
      $display("FAIL single_state got irq=%b bank=%b len=%0d ovf=%b required 1/0/64/0", rx_irq, rd_bank, rd_len, rd_ovf);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_frame(10, 1'b1, 1'b0);
    send_frame(10, 1'b1, 1'b0);
    idle(1);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL b2b_writes got %0d missing required 0", expq.size());
    end
    pulse_rel();
    total++;
    if ({rx_irq, rd_bank, rd_len, rd_ovf} !== {1'b1, 1'b1, 11'd10, 1'b0}) begin
      bad++;
      $display("FAIL b2b_rel1 got irq=%b bank=%b len=%0d ovf=%b required 1/1/10/0", rx_irq, rd_bank, rd_len, rd_ovf);
    end
    pulse_rel();
    total++;
    if ({rx_irq, rd_len, rd_ovf} !== 13'd0) begin
      bad++;
      $display("FAIL b2b_rel2 got irq=%b len=%0d ovf=%b required 0/0/0", rx_irq, rd_len, rd_ovf);
    end
  endtask

  task automatic test_drop();
    do_reset();
    send_frame(12, 1'b1, 1'b0);
    send_frame(7, 1'b1, 1'b0);
    idle(1);
    send_frame(20, 1'b1, 1'b0);
    idle(2);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drop_writes got %0d missing required 0", expq.size());
    end
    total++;
    if ({rx_irq, rd_bank, rd_len, rd_ovf} !== {1'b1, 1'b0, 11'd12, 1'b0}) begin
      bad++;
      $display("FAIL drop_state got irq=%b bank=%b len=%0d ovf=%b required 1/0/12/0", rx_irq, rd_bank, rd_len, rd_ovf);
    end
`ifdef RX_BUF_DROP_CNT_EN
    total++;
    if (drop_cnt !== 16'd1) begin
      bad++;
      $display("FAIL drop_cnt got %0d required 1", drop_cnt);
    end
    pulse_rel();
    pulse_rel();
    total++;
    if (drop_cnt !== 16'd1) begin
      bad++;
      $display("FAIL drop_cnt_keep got %0d required 1", drop_cnt);
    end
    pulse_rel();
    total++;
    if (drop_cnt !== 16'd0) begin
      bad++;
      $display("FAIL drop_cnt_clr got %0d required 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_overflow();
    do_reset();
    send_frame(1100, 1'b1, 1'b0);
    idle(1);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL ovf_writes got %0d missing required 0", expq.size());
    end
    total++;
    if ({rx_irq, rd_bank, rd_len, rd_ovf} !== {1'b1, 1'b0, 11'd1024, 1'b1}) begin
      bad++;
      $display("FAIL ovf_state got irq=%b bank=%b len=%0d ovf=%b required 1/0/1024/1", rx_irq, rd_bank, rd_len, rd_ovf);
    end
  endtask

  task automatic test_commit_rel();
    do_reset();
    send_frame(5, 1'b1, 1'b0);
    idle(1);
    send_frame(7, 1'b1, 1'b1);
    idle(1);
    total++;
    if ({rx_irq, rd_bank, rd_len, rd_ovf} !== {1'b1, 1'b1, 11'd7, 1'b0}) begin
      bad++;
      $display("FAIL commit_rel got irq=%b bank=%b len=%0d ovf=%b required 1/1/7/0", rx_irq, rd_bank, rd_len, rd_ovf);
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL commit_rel_writes got %0d missing required 0", expq.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(6, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge RX_CLK);
      dv = 1'b1; rel = 1'b0;
      din = 8'($urandom);
      expq.push_back({1'b1, 10'(i), din});
    end
    do_reset();
    idle(3);
    total++;
    if ({rx_irq, rd_bank, rd_len, rd_ovf} !== 14'd0) begin
      bad++;
      $display("FAIL midrst_state got irq=%b bank=%b len=%0d ovf=%b required 0", rx_irq, rd_bank, rd_len, rd_ovf);
    end
    send_frame(8, 1'b1, 1'b0);
    idle(1);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL midrst_writes got %0d missing required 0", expq.size());
    end
    total++;
    if ({rx_irq, rd_bank, rd_len, rd_ovf} !== {1'b1, 1'b0, 11'd8, 1'b0}) begin
      bad++;
      $display("FAIL midrst_next got irq=%b bank=%b len=%0d ovf=%b required 1/0/8/0", rx_irq, rd_bank, rd_len, rd_ovf);
    end
  endtask

  task automatic test_random();
    logic [13:0] ex;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act < 6) begin
        int n;
        n = (act == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1020, 1030) : $urandom_range(1, 40);
        send_frame(n, 1'b1, ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 0) idle(1);
      end else if (act < 9) begin
        pulse_rel();
      end else begin
        idle($urandom_range(1, 3));
      end
      idle(1);
      ex = exp_state();
      total++;
      if ({rx_irq, rd_bank, rd_len, rd_ovf} !== ex) begin
        bad++;
        $display("FAIL rand_state it=%0d got irq=%b bank=%b len=%0d ovf=%b required irq=%b bank=%b len=%0d ovf=%b",
                 it, rx_irq, rd_bank, rd_len, rd_ovf, ex[13], ex[12], ex[11:1], ex[0]);
      end
      total++;
      if (expq.size() != 0) begin
        bad++;
        $display("FAIL rand_writes it=%0d got %0d missing required 0", it, expq.size());
      end
`ifdef RX_BUF_DROP_CNT_EN
      total++;
      if (drop_cnt !== 16'(m_drop)) begin
        bad++;
        $display("FAIL rand_drop it=%0d got %0d required %0d", it, drop_cnt, m_drop);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_drop();
    test_overflow();
    test_commit_rel();
    test_reset_mid_frame();
    test_random();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
